// File: rtl/sequential_label_decoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sequential_label_decoder_pkg
//  Description : Shared BP-engine defaults and packed label-vector helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sequential_label_decoder_pkg;

    localparam int c_LABELS        = 16;
    localparam int c_LOG2_LABELS   = 4;
    localparam int c_MESSAGE_WIDTH = 6;
    localparam int c_DATA_WIDTH    = 8;

    // LSB position of a label element inside a packed per-label vector.
    function automatic int unsigned label_lsb(input int unsigned index,
                                              input int unsigned width);
        return index * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sequential_label_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sequential_label_decoder_if
//  Description : Pixel message-bundle input and labelling result bus.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sequential_label_decoder_if #(
    parameter int LABELS        = 16,
    parameter int LOG2_LABELS   = 4,
    parameter int MESSAGE_WIDTH = 6,
    parameter int DATA_WIDTH    = 8,
    parameter int BELIEF_WIDTH  = DATA_WIDTH + 2,
    parameter int PIXEL_WIDTH   = 20,
    parameter int ENERGY_WIDTH  = 32
);

    logic [LABELS*MESSAGE_WIDTH-1:0] horizontal_message_forward;
    logic [LABELS*MESSAGE_WIDTH-1:0] horizontal_message_backward;
    logic [LABELS*MESSAGE_WIDTH-1:0] vertical_message_forward;
    logic [LABELS*MESSAGE_WIDTH-1:0] vertical_message_backward;
    logic [LABELS*DATA_WIDTH-1:0]    data;
    logic                            push;
    logic [PIXEL_WIDTH-1:0]          frame_pixels;
    logic                            valid;
    logic [LOG2_LABELS-1:0]          label;
    logic [BELIEF_WIDTH-1:0]         min_belief;
    logic                            frame_done;
    logic [ENERGY_WIDTH-1:0]         frame_energy;

    modport master (
        output horizontal_message_forward, horizontal_message_backward,
        output vertical_message_forward, vertical_message_backward,
        output data, push, frame_pixels,
        input  valid, label, min_belief, frame_done, frame_energy
    );

    modport slave (
        input  horizontal_message_forward, horizontal_message_backward,
        input  vertical_message_forward, vertical_message_backward,
        input  data, push, frame_pixels,
        output valid, label, min_belief, frame_done, frame_energy
    );

endinterface
`default_nettype wire

// File: rtl/sequential_label_decoder_argmin_tree.sv
`default_nettype none
// ============================================================================
//  Module      : argmin_tree
//  Description : Pipelined min-with-index tree, one register per level,
//                ties resolve to the lowest index.
//  Revision    : 1.0 - initial release
// ============================================================================
module argmin_tree
    import sequential_label_decoder_pkg::*;
#(
    parameter int N      = 16,
    parameter int LOG2_N = 4,
    parameter int WIDTH  = 10
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire [N*WIDTH-1:0]  i_values,
    output logic [WIDTH-1:0]   o_min_value,
    output logic [LOG2_N-1:0]  o_min_index
);

    // Heap layout: node k has children 2k+1 and 2k+2; leaves N-1..2N-2 are
    // the inputs, so a left child always holds the lower label index.
    logic [WIDTH-1:0]  r_val [0:N-2];
    logic [LOG2_N-1:0] r_idx [0:N-2];

    for (genvar k = 0; k < N - 1; k++) begin : g_node
        logic [WIDTH-1:0]  w_lv;
        logic [WIDTH-1:0]  w_rv;
        logic [LOG2_N-1:0] w_li;
        logic [LOG2_N-1:0] w_ri;

        if (2 * k + 1 >= N - 1) begin : g_leaf
            localparam int c_LEFT = 2 * k + 1 - (N - 1);
            assign w_lv = i_values[label_lsb(c_LEFT, WIDTH) +: WIDTH];
            assign w_rv = i_values[label_lsb(c_LEFT + 1, WIDTH) +: WIDTH];
            assign w_li = LOG2_N'(c_LEFT);
            assign w_ri = LOG2_N'(c_LEFT + 1);
        end else begin : g_inner
            assign w_lv = r_val[2 * k + 1];
            assign w_rv = r_val[2 * k + 2];
            assign w_li = r_idx[2 * k + 1];
            assign w_ri = r_idx[2 * k + 2];
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_val[k] <= '0;
                r_idx[k] <= '0;
            end else if (w_rv < w_lv) begin
                r_val[k] <= w_rv;
                r_idx[k] <= w_ri;
            end else begin
                r_val[k] <= w_lv;
                r_idx[k] <= w_li;
            end
        end
    end

    assign o_min_value = r_val[0];
    assign o_min_index = r_idx[0];

endmodule
`default_nettype wire

// File: rtl/sequential_label_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sequential_label_decoder
//  Description : Per-pixel belief argmin labelling with frame energy totals.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequential_label_decoder
    import sequential_label_decoder_pkg::*;
#(
    parameter int LABELS        = c_LABELS,
    parameter int LOG2_LABELS   = c_LOG2_LABELS,
    parameter int MESSAGE_WIDTH = c_MESSAGE_WIDTH,
    parameter int DATA_WIDTH    = c_DATA_WIDTH,
    parameter int BELIEF_WIDTH  = DATA_WIDTH + 2,
    parameter int PIXEL_WIDTH   = 20,
    parameter int ENERGY_WIDTH  = 32
) (
    input  wire                        clk,
    input  wire                        rst_n,
    sequential_label_decoder_if.slave  bus
);

    localparam int c_STAGES = 3 + LOG2_LABELS;
    localparam int c_ACC_W  = ENERGY_WIDTH + 1;
    localparam int c_MW     = MESSAGE_WIDTH;
    localparam int c_DW     = DATA_WIDTH;
    localparam int c_BW     = BELIEF_WIDTH;

    logic [c_STAGES-1:0]             r_vld;
    logic [LABELS*c_MW-1:0]          r_hf;
    logic [LABELS*c_MW-1:0]          r_hb;
    logic [LABELS*c_MW-1:0]          r_vf;
    logic [LABELS*c_MW-1:0]          r_vb;
    logic [LABELS*c_DW-1:0]          r_data;
    logic [LABELS*c_BW-1:0]          r_pair_a;
    logic [LABELS*c_BW-1:0]          r_pair_b;
    logic [LABELS*c_BW-1:0]          r_belief;
    logic [c_BW-1:0]                 w_tree_val;
    logic [LOG2_LABELS-1:0]          w_tree_idx;
    logic [PIXEL_WIDTH-1:0]          r_count;
    logic [ENERGY_WIDTH-1:0]         r_acc;
    logic [c_ACC_W-1:0]              w_acc_sum;
    logic [ENERGY_WIDTH-1:0]         w_acc_next;
    logic                            w_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[c_STAGES-2:0], bus.push};
        end
    end

    // Datapath carries no reset: only r_vld qualifies it.
    always_ff @(posedge clk) begin
        r_hf   <= bus.horizontal_message_forward;
        r_hb   <= bus.horizontal_message_backward;
        r_vf   <= bus.vertical_message_forward;
        r_vb   <= bus.vertical_message_backward;
        r_data <= bus.data;
        for (int i = 0; i < LABELS; i++) begin
            r_pair_a[label_lsb(i, c_BW) +: c_BW] <=
                c_BW'(r_data[label_lsb(i, c_DW) +: c_DW]) +
                c_BW'(r_hf[label_lsb(i, c_MW) +: c_MW]) +
                c_BW'(r_vf[label_lsb(i, c_MW) +: c_MW]);
            r_pair_b[label_lsb(i, c_BW) +: c_BW] <=
                c_BW'(r_hb[label_lsb(i, c_MW) +: c_MW]) +
                c_BW'(r_vb[label_lsb(i, c_MW) +: c_MW]);
            r_belief[label_lsb(i, c_BW) +: c_BW] <=
                r_pair_a[label_lsb(i, c_BW) +: c_BW] +
                r_pair_b[label_lsb(i, c_BW) +: c_BW];
        end
    end

    argmin_tree #(
        .N      (LABELS),
        .LOG2_N (LOG2_LABELS),
        .WIDTH  (c_BW)
    ) u_argmin_tree (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_values    (r_belief),
        .o_min_value (w_tree_val),
        .o_min_index (w_tree_idx)
    );

    // frame_pixels of zero collapses to one-pixel frames.
    assign w_last     = (bus.frame_pixels == '0) ||
                        (r_count == bus.frame_pixels - PIXEL_WIDTH'(1));
    assign w_acc_sum  = {1'b0, r_acc} + c_ACC_W'(w_tree_val);
    assign w_acc_next = w_acc_sum[ENERGY_WIDTH] ? '1 : w_acc_sum[ENERGY_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.valid        <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.label        <= '0;
            bus.min_belief   <= '0;
            bus.frame_energy <= '0;
            r_count          <= '0;
            r_acc            <= '0;
        end else begin
            bus.valid      <= r_vld[c_STAGES-1];
            bus.frame_done <= 1'b0;
            if (r_vld[c_STAGES-1]) begin
                bus.label      <= w_tree_idx;
                bus.min_belief <= w_tree_val;
                if (w_last) begin
                    bus.frame_done   <= 1'b1;
                    bus.frame_energy <= w_acc_next;
                    r_acc            <= '0;
                    r_count          <= '0;
                end else begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + PIXEL_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sequential_label_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequential_label_decoder
//  Description : Directed scoreboard bench for the label decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_label_decoder;
    import sequential_label_decoder_pkg::*;

    typedef struct {
        int unsigned     lbl;
        int unsigned     bel;
        bit              done;
        longint unsigned energy;
        int unsigned     cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    int unsigned cyc   = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        q1[$];
    exp_t        q2[$];
    logic [7:0]  d  [16];
    logic [5:0]  hf [16];
    logic [5:0]  hb [16];
    logic [5:0]  vf [16];
    logic [5:0]  vb [16];
    int unsigned last_l = 0;
    int unsigned last_b = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sequential_label_decoder_if #(.ENERGY_WIDTH(32)) bus ();
    sequential_label_decoder_if #(.ENERGY_WIDTH(10)) bus2 ();

    assign bus2.horizontal_message_forward  = bus.horizontal_message_forward;
    assign bus2.horizontal_message_backward = bus.horizontal_message_backward;
    assign bus2.vertical_message_forward    = bus.vertical_message_forward;
    assign bus2.vertical_message_backward   = bus.vertical_message_backward;
    assign bus2.data                        = bus.data;
    assign bus2.push                        = bus.push;
    assign bus2.frame_pixels                = bus.frame_pixels;

    sequential_label_decoder #(.ENERGY_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    sequential_label_decoder #(.ENERGY_WIDTH(10)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2)
    );

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fill(input int dv, input int mv);
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'(dv); hf[i] = 6'(mv); hb[i] = 6'(mv); vf[i] = 6'(mv); vb[i] = 6'(mv);
        end
    endtask

    task automatic load();
        for (int i = 0; i < 16; i++) begin
            bus.data[i*8 +: 8]                        = d[i];
            bus.horizontal_message_forward[i*6 +: 6]  = hf[i];
            bus.horizontal_message_backward[i*6 +: 6] = hb[i];
            bus.vertical_message_forward[i*6 +: 6]    = vf[i];
            bus.vertical_message_backward[i*6 +: 6]   = vb[i];
        end
    endtask

    // Called at a falling edge; the push is sampled on the next rising edge.
    task automatic push_pixel(input int unsigned lbl, input int unsigned bel,
                              input bit done, input longint unsigned e1,
                              input bit to2, input longint unsigned e2);
        load();
        bus.push = 1'b1;
        q1.push_back(exp_t'{lbl, bel, done, e1, cyc + 8});
        if (to2) q2.push_back(exp_t'{lbl, bel, done, e2, cyc + 8});
        @(negedge clk);
        bus.push = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            last_l = 0;
            last_b = 0;
        end else if (bus.valid) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid: got valid=1, expected no output (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                chk("label",        bus.label,        e.lbl);
                chk("min_belief",   bus.min_belief,   e.bel);
                chk("frame_done",   bus.frame_done,   e.done);
                chk("frame_energy", bus.frame_energy, e.energy);
                chk("latency_cycle", cyc, e.cyc);
            end
            last_l = bus.label;
            last_b = bus.min_belief;
        end else begin
            chk("hold_label",      bus.label,      last_l);
            chk("hold_min_belief", bus.min_belief, last_b);
            chk("idle_frame_done", bus.frame_done, 0);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst2_n && bus2.valid) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid_e10: got valid=1, expected no output (cycle %0d)", cyc);
            end else begin
                e = q2.pop_front();
                chk("label_e10",        bus2.label,        e.lbl);
                chk("min_belief_e10",   bus2.min_belief,   e.bel);
                chk("frame_done_e10",   bus2.frame_done,   e.done);
                chk("frame_energy_e10", bus2.frame_energy, e.energy);
                chk("latency_e10",      cyc,               e.cyc);
            end
        end
    end

    initial begin
        bus.push = 1'b0;
        bus.frame_pixels = 20'd1;
        fill(0, 0);
        load();
        repeat (3) @(negedge clk);
        chk("reset_valid",        bus.valid,        0);
        chk("reset_frame_done",   bus.frame_done,   0);
        chk("reset_label",        bus.label,        0);
        chk("reset_min_belief",   bus.min_belief,   0);
        chk("reset_frame_energy", bus.frame_energy, 0);
        rst_n = 1'b1;
        idle(2);

        // Single pixel, one-pixel frames
        fill(100, 0); d[5] = 3;
        push_pixel(5, 3, 1, 3, 0, 0);
        idle(10);

        // Maximum beliefs with a full tie, then a tie between two zeros
        fill(255, 63);
        push_pixel(0, 507, 1, 507, 0, 0);
        d[9] = 0; d[12] = 0;
        push_pixel(9, 252, 1, 252, 0, 0);
        idle(10);

        // Back-to-back stream, four-pixel frames
        bus.frame_pixels = 20'd4;
        for (int p = 0; p < 8; p++) begin
            fill(100, 0); d[p] = 8'(p);
            push_pixel(p, p, (p == 3) || (p == 7),
                       (p < 3) ? 252 : (p == 7) ? 22 : 6, 0, 0);
        end
        idle(10);

        // Bubble pattern 1,0,1,1,0 then close the frame
        fill(200, 0); d[2] = 7;
        push_pixel(2, 7, 0, 22, 0, 0);
        idle(1);
        fill(200, 0); d[11] = 8;
        push_pixel(11, 8, 0, 22, 0, 0);
        fill(200, 0); d[15] = 9;
        push_pixel(15, 9, 0, 22, 0, 0);
        idle(1);
        fill(200, 0); d[0] = 1;
        push_pixel(0, 1, 1, 25, 0, 0);
        idle(10);

        // Reset mid-operation: leave a frame half done, drop three pixels
        bus.frame_pixels = 20'd2;
        fill(200, 0); d[3] = 10;
        push_pixel(3, 10, 0, 25, 0, 0);
        idle(10);
        fill(50, 1);
        load();
        bus.push = 1'b1;
        idle(3);
        bus.push = 1'b0;
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(12);
        fill(200, 0); d[4] = 4;
        push_pixel(4, 4, 0, 0, 0, 0);
        fill(200, 0); d[6] = 5;
        push_pixel(6, 5, 1, 9, 0, 0);
        idle(10);

        // Energy saturation on the 10-bit energy instance
        bus.frame_pixels = 20'd4;
        rst2_n = 1'b1;
        idle(2);
        fill(255, 0);
        for (int i = 0; i < 16; i++) begin
            hf[i] = 6'd63; hb[i] = 6'd63; vf[i] = 6'd19;
        end
        for (int p = 0; p < 4; p++) begin
            push_pixel(0, 400, p == 3, (p == 3) ? 1600 : 9, 1, (p == 3) ? 1023 : 0);
        end
        idle(10);
        rst2_n = 1'b0;

        // frame_pixels of zero acts as one
        bus.frame_pixels = 20'd0;
        fill(200, 0); d[1] = 2;
        push_pixel(1, 2, 1, 2, 0, 0);
        fill(200, 0); d[14] = 3;
        push_pixel(14, 3, 1, 3, 0, 0);

        for (int i = 0; i < 50 && (q1.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        chk("outstanding_outputs", q1.size() + q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
